mips_if_stage: RTL and testbench

//  Instruction-fetch stage of MIPS_Pipeline: owns the PC, drives the instruction-memory read port,
//  and registers fetched words into the IF/ID pipeline register consumed by decode.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mips_ifid_reg.sv | 36 +++
 rtl/mips_if_stage.sv | 120 ++++++++++++
 tb/tb_mips_if_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: fixed encodings, PC step
// and the fetch-state type used by the IF stage.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned PC_STEP            = 4;

    typedef enum logic {
        IF_RUN    = 1'b0,
        IF_HALTED = 1'b1
    } if_state_t;

endpackage

// File: rtl/mips_ifid_reg.sv
// IF/ID pipeline register: bubble clears the instruction and valid flag, hold
// freezes contents, load captures a fetched word with its PC+4.
module mips_ifid_reg
    import mips_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bubble,
    input  logic          hold,
    input  logic          load,
    input  logic [31:0]   instr_d,
    input  logic [AW-1:0] pc4_d,
    output logic [31:0]   instr,
    output logic [AW-1:0] pc4,
    output logic          valid
);

    // Bubble outranks hold so a flush always wins; pc4 is kept on a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!hold && load) begin
            instr <= instr_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/mips_if_stage.sv
// Instruction-fetch stage: PC register, RUN/HALTED FSM, redirect/flush/stall
// priority and IF/ID register. Optional fetch counter under IF_FETCH_CNT_EN.
module mips_if_stage
    import mips_pkg::*;
#(
    parameter int            AW         = 32,
    parameter logic [AW-1:0] RESET_PC   = '0,
    parameter logic [31:0]   HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] imem_addr_o,
    input  logic [31:0]   imem_rdata_i,
    input  logic          stall_i,
    input  logic          redirect_valid_i,
    input  logic [AW-1:0] redirect_pc_i,
    input  logic          flush_i,
    output logic [31:0]   ifid_instr_o,
    output logic [AW-1:0] ifid_pc4_o,
    output logic          ifid_valid_o,
    output logic          halted_o,
    output logic [31:0]   fetch_cnt_o
);

    if_state_t     state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] redir_pc;
    logic          fetch_halt;
    logic          ifid_bubble, ifid_hold, ifid_load;

    assign pc_inc      = pc_q + AW'(PC_STEP);
    assign redir_pc    = {redirect_pc_i[AW-1:2], 2'b00};
    assign fetch_halt  = (imem_rdata_i == HALT_INSTR);
    assign imem_addr_o = pc_q;
    assign halted_o    = (state_q == IF_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Priority in RUN: redirect > flush > stall > normal fetch (or HALT detect).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_bubble = 1'b0;
        ifid_hold   = 1'b0;
        ifid_load   = 1'b0;
        case (state_q)
            IF_RUN: begin
                if (redirect_valid_i) begin
                    pc_d        = redir_pc;
                    ifid_bubble = 1'b1;
                end else if (flush_i) begin
                    ifid_bubble = 1'b1;
                    if (!stall_i) begin
                        pc_d = pc_inc;
                    end
                end else if (stall_i) begin
                    ifid_hold = 1'b1;
                end else if (fetch_halt) begin
                    ifid_bubble = 1'b1;
                    state_d     = IF_HALTED;
                end else begin
                    pc_d      = pc_inc;
                    ifid_load = 1'b1;
                end
            end
            IF_HALTED: begin
                ifid_bubble = 1'b1;
                if (redirect_valid_i) begin
                    pc_d    = redir_pc;
                    state_d = IF_RUN;
                end
            end
            default: begin
                state_d     = IF_RUN;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    mips_ifid_reg #(
        .AW(AW)
    ) u_ifid (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (ifid_bubble),
        .hold    (ifid_hold),
        .load    (ifid_load),
        .instr_d (imem_rdata_i),
        .pc4_d   (pc_inc),
        .instr   (ifid_instr_o),
        .pc4     (ifid_pc4_o),
        .valid   (ifid_valid_o)
    );

`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
        end else if (ifid_load) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
`else
    assign fetch_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_mips_if_stage.sv
// Self-checking bench for mips_if_stage against a transaction-level fetch model.
module tb_mips_if_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef IF_FETCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        flush_i = 1'b0;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic [31:0] fetch_cnt_o;

    int errors = 0;
    int checks = 0;

    // Instruction memory: word index xor salt, HALT at one chosen address.
    logic [31:0] halt_addr = 32'hFFFF_FFF0;
    logic [31:0] salt = 32'h0;
    assign imem_rdata_i = (imem_addr_o == halt_addr) ? HALT
                        : (((imem_addr_o >> 2) ^ salt) & 32'h0FFF_FFFF);

    // Reference state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    mips_if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .flush_i          (flush_i),
        .ifid_instr_o     (ifid_instr_o),
        .ifid_pc4_o       (ifid_pc4_o),
        .ifid_valid_o     (ifid_valid_o),
        .halted_o         (halted_o),
        .fetch_cnt_o      (fetch_cnt_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == halt_addr) return HALT;
        return ((a >> 2) ^ salt) & 32'h0FFF_FFFF;
    endfunction

    function automatic logic [31:0] exp_cnt();
        return CNT_EN ? m_cnt : 32'h0;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // Hold reset across an edge, then release it mid-cycle.
    task automatic do_reset();
        stall_i = 1'b0; redirect_valid_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock with the given inputs; advances the reference model by the fetch rules.
    task automatic step(input logic st, input logic rv, input logic [31:0] rp, input logic fl);
        logic [31:0] w;
        stall_i = st; redirect_valid_i = rv; redirect_pc_i = rp; flush_i = fl;
        w = mem_word(m_pc);
        if (m_halted) begin
            m_valid = 1'b0; m_instr = 32'h0;
            if (rv) begin m_pc = rp & ~32'h3; m_halted = 1'b0; end
        end else if (rv) begin
            m_pc = rp & ~32'h3; m_valid = 1'b0; m_instr = 32'h0;
        end else if (fl) begin
            m_valid = 1'b0; m_instr = 32'h0;
            if (!st) m_pc = m_pc + 32'd4;
        end else if (st) begin
            // everything holds
        end else if (w == HALT) begin
            m_valid = 1'b0; m_instr = 32'h0; m_halted = 1'b1;
        end else begin
            m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk); #1;
        stall_i = 1'b0; redirect_valid_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, 32'h0); end
        checks++; if (ifid_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr_o, 32'h0); end
        checks++; if (ifid_pc4_o !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", ifid_pc4_o, 32'h0); end
        checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid_o); end
        checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted_o); end
        checks++; if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt_o); end
        do_reset();
    endtask

    task automatic test_sequential();
        salt = 32'h0; halt_addr = 32'hFFFF_FFF0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            checks++; if (ifid_pc4_o !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, ifid_pc4_o, 32'(4 * (i + 1))); end
            checks++; if (ifid_instr_o !== 32'(i)) begin errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, ifid_instr_o, 32'(i)); end
            checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, ifid_valid_o); end
            checks++; if (imem_addr_o !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr_o, 32'(4 * (i + 1))); end
        end
    endtask

    task automatic test_stall();
        salt = 32'h0; halt_addr = 32'hFFFF_FFF0;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=10", i, imem_addr_o); end
            checks++; if (ifid_instr_o !== 32'h3 || ifid_pc4_o !== 32'h10 || ifid_valid_o !== 1'b1) begin
                errors++; $display("FAIL stall_ifid[%0d] got=%h/%h/%b exp=3/10/1", i, ifid_instr_o, ifid_pc4_o, ifid_valid_o); end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (imem_addr_o !== 32'h14 || ifid_instr_o !== 32'h4 || ifid_pc4_o !== 32'h14) begin
            errors++; $display("FAIL stall_resume got=%h/%h/%h exp=14/4/14", imem_addr_o, ifid_instr_o, ifid_pc4_o); end
    endtask

    task automatic test_redirect_stall();
        step(1'b1, 1'b1, 32'h43, 1'b0);
        checks++; if (imem_addr_o !== 32'h40) begin errors++; $display("FAIL redir_addr got=%h exp=40", imem_addr_o); end
        checks++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0) begin errors++; $display("FAIL redir_bubble got=%b/%h exp=0/0", ifid_valid_o, ifid_instr_o); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h10 || ifid_pc4_o !== 32'h44) begin
            errors++; $display("FAIL redir_fetch got=%b/%h/%h exp=1/10/44", ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
    endtask

    task automatic test_halt();
        salt = 32'h0; halt_addr = 32'h20;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted_o); end
        checks++; if (imem_addr_o !== 32'h20 || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL halt_state got=%h/%b exp=20/0", imem_addr_o, ifid_valid_o); end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (halted_o !== 1'b1 || imem_addr_o !== 32'h20 || ifid_valid_o !== 1'b0) begin
            errors++; $display("FAIL halt_hold got=%b/%h/%b exp=1/20/0", halted_o, imem_addr_o, ifid_valid_o); end
        step(1'b0, 1'b1, 32'h0, 1'b0);
        checks++; if (halted_o !== 1'b0 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL halt_exit got=%b/%h exp=0/0", halted_o, imem_addr_o); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h4 || ifid_instr_o !== 32'h0) begin
            errors++; $display("FAIL halt_refetch got=%b/%h/%h exp=1/4/0", ifid_valid_o, ifid_pc4_o, ifid_instr_o); end
    endtask

    task automatic test_async_reset();
        salt = 32'h0; halt_addr = 32'hFFFF_FFF0;
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (imem_addr_o !== 32'h1C) begin errors++; $display("FAIL arst_pre got=%h exp=1c", imem_addr_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_addr_o !== 32'h0 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin
            errors++; $display("FAIL arst_out got=%h/%b/%h/%h exp=0/0/0/0", imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
        checks++; if (halted_o !== 1'b0 || fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL arst_ctl got=%b/%0d exp=0/0", halted_o, fetch_cnt_o); end
        do_reset();
    endtask

    task automatic test_counter();
        salt = 32'h0; halt_addr = 32'hFFFF_FFF0;
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (fetch_cnt_o !== (CNT_EN ? 32'd10 : 32'd0)) begin
            errors++; $display("FAIL cnt_value got=%0d exp=%0d", fetch_cnt_o, CNT_EN ? 10 : 0); end
        checks++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 32'h2C) begin
            errors++; $display("FAIL cnt_flush got=%b/%h exp=0/2c", ifid_valid_o, imem_addr_o); end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redir got=%h exp=fffffffc", imem_addr_o); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (imem_addr_o !== 32'h0 || ifid_pc4_o !== 32'h0 || ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h0FFF_FFFF) begin
            errors++; $display("FAIL wrap_fetch got=%h/%h/%b/%h exp=0/0/1/0fffffff", imem_addr_o, ifid_pc4_o, ifid_valid_o, ifid_instr_o); end
    endtask

    task automatic test_random();
        salt = $urandom & 32'h0FFF_FFFF;
        halt_addr = 32'(4 * $urandom_range(4, 40));
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 32'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
            checks++;
            if (imem_addr_o !== m_pc || ifid_valid_o !== m_valid || ifid_instr_o !== m_instr ||
                halted_o !== m_halted || fetch_cnt_o !== exp_cnt() || (m_valid && ifid_pc4_o !== m_pc4)) begin
                errors++;
                $display("FAIL rand[%0d] got=%h/%b/%h/%h/%b/%0d exp=%h/%b/%h/%h/%b/%0d", i,
                         imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o, halted_o, fetch_cnt_o,
                         m_pc, m_valid, m_instr, m_pc4, m_halted, exp_cnt());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_async_reset();
        test_counter();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
